// File: rtl/stream_downsizer_if.sv
// Stream downsizer bus: upstream word channel, downstream slice channel and flush.
// The slave modport is the downsizer; the master modport is the environment around it.
interface stream_downsizer_if #(
    parameter int InWidth  = 64,
    parameter int OutWidth = 16,
    parameter int LenWidth = $clog2(InWidth / OutWidth)
);
    logic                enq_vld_i;
    logic [InWidth-1:0]  enq_payload_i;
    logic [LenWidth-1:0] enq_len_i;
    logic                enq_rdy_o;
    logic                deq_vld_o;
    logic [OutWidth-1:0] deq_payload_o;
    logic                deq_last_o;
    logic                deq_rdy_i;
    logic                flush_i;

    modport slave (
        input  enq_vld_i, enq_payload_i, enq_len_i, deq_rdy_i, flush_i,
        output enq_rdy_o, deq_vld_o, deq_payload_o, deq_last_o
    );

    modport master (
        output enq_vld_i, enq_payload_i, enq_len_i, deq_rdy_i, flush_i,
        input  enq_rdy_o, deq_vld_o, deq_payload_o, deq_last_o
    );
endinterface

// File: rtl/stream_downsizer.sv
// Splits one InWidth word into up to Ratio OutWidth slices, least-significant first.
// The held word shifts right per slice so the output slice comes straight from flops.
module stream_downsizer #(
    parameter int InWidth  = 64,
    parameter int OutWidth = 16,
    parameter int LenWidth = $clog2(InWidth / OutWidth)
) (
    input  logic               clk,
    input  logic               rst,
    stream_downsizer_if.slave  bus
);
    localparam int Ratio = InWidth / OutWidth;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [LenWidth-1:0] MaxLen = LenWidth'(Ratio - 1);

    // Out-of-range slice counts saturate to a full word.
    function automatic logic [LenWidth-1:0] clamp_len(input logic [LenWidth-1:0] len_in);
        if (int'(len_in) > Ratio - 1) begin
            return MaxLen;
        end else begin
            return len_in;
        end
    endfunction

    logic [0:0]          state_r;
    logic [LenWidth-1:0] idx_r;
    logic [LenWidth-1:0] len_r;
    logic [InWidth-1:0]  held_r;

    logic busy_s;
    logic deq_last_s;
    logic enq_rdy_s;
    logic enq_fire_s;
    logic deq_fire_s;

    // Handshake decode; deq_rdy_i and flush_i are the only inputs reaching enq_rdy.
    always_comb begin
        busy_s     = 1'b0;
        deq_last_s = 1'b0;
        enq_rdy_s  = 1'b0;
        enq_fire_s = 1'b0;
        deq_fire_s = 1'b0;
        if (state_r == BUSY) begin
            busy_s     = 1'b1;
            deq_last_s = (idx_r == len_r);
        end else begin
            busy_s     = 1'b0;
            deq_last_s = 1'b0;
        end
        enq_rdy_s  = ((state_r == IDLE) || (deq_last_s && bus.deq_rdy_i)) && !bus.flush_i;
        enq_fire_s = bus.enq_vld_i && enq_rdy_s;
        deq_fire_s = busy_s && bus.deq_rdy_i;
    end

    assign bus.enq_rdy_o     = enq_rdy_s;
    assign bus.deq_vld_o     = busy_s;
    assign bus.deq_last_o    = deq_last_s;
    assign bus.deq_payload_o = held_r[OutWidth-1:0];

    // Word holding, slice stepping, flush and reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            len_r   <= '0;
            held_r  <= '0;
        end else if (bus.flush_i) begin
            state_r <= IDLE;
            idx_r   <= '0;
            len_r   <= '0;
            held_r  <= '0;
        end else if (enq_fire_s) begin
            // Covers the last-slice/new-word overlap, so no bubble is inserted.
            state_r <= BUSY;
            idx_r   <= '0;
            len_r   <= clamp_len(bus.enq_len_i);
            held_r  <= bus.enq_payload_i;
        end else if (deq_fire_s) begin
            if (deq_last_s) begin
                state_r <= IDLE;
                idx_r   <= '0;
            end else begin
                idx_r  <= idx_r + 1'b1;
                held_r <= held_r >> OutWidth;
            end
        end else begin
            state_r <= state_r;
            idx_r   <= idx_r;
            len_r   <= len_r;
            held_r  <= held_r;
        end
    end
endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: directed cycle checks, a vector table,
// and a scoreboard of expected slices filled at enq fire and drained at deq fire.
module tb_stream_downsizer;
    localparam int InWidth  = 64;
    localparam int OutWidth = 16;
    localparam int LenWidth = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_downsizer_if #(.InWidth(InWidth), .OutWidth(OutWidth), .LenWidth(LenWidth)) bus ();

    stream_downsizer #(.InWidth(InWidth), .OutWidth(OutWidth), .LenWidth(LenWidth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] payload;
        logic [1:0]  len;
        int          exp_slices;
    } vec_t;

    vec_t        vecs[6];
    logic [16:0] sb[$];
    int          errors = 0;
    int          checks = 0;
    int          slice_cnt = 0;
    logic [15:0] exp1[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] p, input logic [1:0] l);
        int n;
        n = (int'(l) >= 3) ? 4 : int'(l) + 1;
        for (int k = 0; k < n; k++) begin
            sb.push_back({(k == n - 1) ? 1'b1 : 1'b0, p[k*16 +: 16]});
        end
    endtask

    // Scoreboard: pop on deq fire, drop on flush, push on enq fire.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.deq_vld_o && bus.deq_rdy_i) begin
                slice_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got slice %h expected none", bus.deq_payload_o);
                end else begin
                    check("sb_slice", {47'd0, bus.deq_last_o, bus.deq_payload_o}, {47'd0, sb.pop_front()});
                end
            end
            if (bus.flush_i) sb.delete();
            if (bus.enq_vld_i && bus.enq_rdy_o) push_word(bus.enq_payload_i, bus.enq_len_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit rand_bp);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.deq_vld_o) && n < 200) begin
            bus.deq_rdy_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        bus.deq_rdy_i = 1'b1;
        check("drain_timeout", {63'd0, n >= 200}, 64'd0);
    endtask

    task automatic enq(input logic [63:0] p, input logic [1:0] l);
        bus.enq_vld_i     = 1'b1;
        bus.enq_payload_i = p;
        bus.enq_len_i     = l;
    endtask

    initial begin
        rst               = 1'b1;
        bus.enq_vld_i     = 1'b0;
        bus.enq_payload_i = 64'd0;
        bus.enq_len_i     = 2'd0;
        bus.deq_rdy_i     = 1'b1;
        bus.flush_i       = 1'b0;
        exp1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        vecs[0] = '{64'h0123_4567_89AB_CDEF, 2'd3, 4};
        vecs[1] = '{64'hFFFF_0000_FFFF_0000, 2'd0, 1};
        vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D, 2'd1, 2};
        vecs[3] = '{64'h8000_0001_7FFE_0002, 2'd2, 3};
        vecs[4] = '{64'h0000_0000_0000_0000, 2'd3, 4};
        vecs[5] = '{64'hA5A5_5A5A_3C3C_C3C3, 2'd0, 1};

        #12;
        check("rst_deq_vld", {63'd0, bus.deq_vld_o}, 64'd0);
        check("rst_deq_last", {63'd0, bus.deq_last_o}, 64'd0);
        check("rst_enq_rdy", {63'd0, bus.enq_rdy_o}, 64'd1);
        check("rst_payload", {48'd0, bus.deq_payload_o}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single word, full rate.
        enq(64'h4444_3333_2222_1111, 2'd3);
        tick();
        bus.enq_vld_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("single_vld", {63'd0, bus.deq_vld_o}, 64'd1);
            check("single_payload", {48'd0, bus.deq_payload_o}, {48'd0, exp1[k]});
            check("single_last", {63'd0, bus.deq_last_o}, (k == 3) ? 64'd1 : 64'd0);
            tick();
        end
        check("single_idle", {63'd0, bus.deq_vld_o}, 64'd0);

        // Back-to-back words with enq_vld held high.
        enq(64'h0000_0000_BBBB_AAAA, 2'd1);
        tick();
        enq(64'h0000_0000_DDDD_CCCC, 2'd1);
        check("b2b_aaaa", {48'd0, bus.deq_payload_o}, 64'h0000_0000_0000_AAAA);
        check("b2b_rdy_mid", {63'd0, bus.enq_rdy_o}, 64'd0);
        tick();
        check("b2b_bbbb", {48'd0, bus.deq_payload_o}, 64'h0000_0000_0000_BBBB);
        check("b2b_rdy_last", {63'd0, bus.enq_rdy_o}, 64'd1);
        tick();
        bus.enq_vld_i = 1'b0;
        check("b2b_cccc", {47'd0, bus.deq_vld_o, bus.deq_payload_o}, 64'h0000_0000_0001_CCCC);
        tick();
        check("b2b_dddd", {47'd0, bus.deq_last_o, bus.deq_payload_o}, 64'h0000_0000_0001_DDDD);
        tick();
        check("b2b_idle", {63'd0, bus.deq_vld_o}, 64'd0);

        // Backpressure at idx=1 with a different word offered meanwhile.
        enq(64'h4444_3333_2222_1111, 2'd3);
        tick();
        bus.enq_vld_i = 1'b0;
        tick();
        bus.deq_rdy_i = 1'b0;
        enq(64'h9999_9999_9999_9999, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_payload", {48'd0, bus.deq_payload_o}, 64'h0000_0000_0000_2222);
            check("bp_enq_rdy", {63'd0, bus.enq_rdy_o}, 64'd0);
            check("bp_last", {62'd0, bus.deq_vld_o, bus.deq_last_o}, 64'd2);
        end
        bus.enq_vld_i = 1'b0;
        drain(1'b0);

        // Short word.
        enq(64'h0000_0000_0000_00FF, 2'd0);
        tick();
        bus.enq_vld_i = 1'b0;
        check("short_slice", {46'd0, bus.deq_vld_o, bus.deq_last_o, bus.deq_payload_o}, 64'h0000_0000_0003_00FF);
        check("short_enq_rdy", {63'd0, bus.enq_rdy_o}, 64'd1);
        tick();
        check("short_idle", {63'd0, bus.deq_vld_o}, 64'd0);

        // Flush at idx=2 with a word offered on the flush edge.
        enq(64'h4444_3333_2222_1111, 2'd3);
        tick();
        bus.enq_vld_i = 1'b0;
        tick();
        tick();
        check("flush_pre", {48'd0, bus.deq_payload_o}, 64'h0000_0000_0000_3333);
        bus.flush_i = 1'b1;
        enq(64'hAAAA_AAAA_AAAA_AAAA, 2'd3);
        #1;
        check("flush_enq_rdy", {63'd0, bus.enq_rdy_o}, 64'd0);
        tick();
        bus.flush_i   = 1'b0;
        bus.enq_vld_i = 1'b0;
        check("flush_vld", {63'd0, bus.deq_vld_o}, 64'd0);
        enq(64'h8888_7777_6666_5555, 2'd3);
        tick();
        bus.enq_vld_i = 1'b0;
        check("flush_restart", {48'd0, bus.deq_payload_o}, 64'h0000_0000_0000_5555);
        drain(1'b0);

        // Vector table under random backpressure.
        foreach (vecs[i]) begin
            int base;
            int n;
            bit fired;
            base = slice_cnt;
            enq(vecs[i].payload, vecs[i].len);
            n = 0;
            fired = 1'b0;
            while (!fired && n < 50) begin
                @(negedge clk);
                fired = bus.enq_rdy_o;
                tick();
                n++;
            end
            bus.enq_vld_i = 1'b0;
            check("tbl_accept", {63'd0, fired}, 64'd1);
            drain(1'b1);
            check("tbl_slices", 64'(slice_cnt - base), 64'(vecs[i].exp_slices));
        end

        // Asynchronous reset between edges at idx=1.
        enq(64'h4444_3333_2222_1111, 2'd3);
        tick();
        bus.enq_vld_i = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("arst_vld", {63'd0, bus.deq_vld_o}, 64'd0);
        check("arst_rdy", {63'd0, bus.enq_rdy_o}, 64'd1);
        check("arst_payload", {47'd0, bus.deq_last_o, bus.deq_payload_o}, 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("arst_quiet", {63'd0, bus.deq_vld_o}, 64'd0);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
